apb_accel_ctrl: RTL and testbench

Multi-channel APB control/status block for the accelerator subsystem, replacing the single-channel start/done register set. Issues one-cycle start pulses to up to NUM_CH independent engines (pool, conv, etc.), tracks per-channel busy state and latency in cycles, latches completion and misuse flags, and raises a maskable interrupt. Sits on the CPU APB bus alongside the other peripheral register blocks.

---
 rtl/apb_accel_ctrl_if.sv | 19 +
 rtl/apb_accel_ctrl.sv | 177 +++++++++++++++++
 tb/tb_apb_accel_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_accel_ctrl_if.sv
// APB completer-side bus bundle for the accelerator control block.
interface apb_accel_ctrl_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA
  );
endinterface

// File: rtl/apb_accel_ctrl.sv
// Multi-channel APB control/status block: start pulses, per-channel busy
// tracking and latency counters, sticky done/error flags, maskable irq.
module apb_accel_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              PCLK,
  input  logic              PRESETB,
  apb_accel_ctrl_if.slave   apb,
  input  logic [NUM_CH-1:0] acc_done,
  output logic [NUM_CH-1:0] acc_start,
  output logic              irq
);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [29:0]      W_CTRL   = 30'd0;
  localparam logic [29:0]      W_STATUS = 30'd1;
  localparam logic [29:0]      W_IRQ_EN = 30'd2;
  localparam logic [29:0]      W_ERR    = 30'd3;
  localparam logic [29:0]      W_CYC0   = 30'd4;

  logic [29:0]       addr_word_s;
  logic              wr_en_s;
  logic              rd_setup_s;
  logic              rd_access_s;
  logic [NUM_CH-1:0] wdata_s;
  logic [NUM_CH-1:0] start_req_s;
  logic [NUM_CH-1:0] sts_clr_s;
  logic [NUM_CH-1:0] err_clr_s;
  logic              irq_en_wr_s;
  logic              cyc_hit_s;
  logic [CNT_W-1:0]  cyc_rd_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  logic [NUM_CH-1:0] busy_r;
  logic [NUM_CH-1:0] busy_nxt_s;
  logic [NUM_CH-1:0] start_fire_s;
  logic [NUM_CH-1:0] err_set_s;
  logic [NUM_CH-1:0] done_set_s;
  logic [NUM_CH-1:0] acc_start_r;
  logic [NUM_CH-1:0] done_sts_r;
  logic [NUM_CH-1:0] err_sts_r;
  logic [NUM_CH-1:0] irq_en_r;
  logic [CNT_W-1:0]  cycles_r [NUM_CH];
  logic [31:0]       prdata_r;

  assign addr_word_s = apb.PADDR[31:2];
  assign wr_en_s     = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_setup_s  = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
  assign rd_access_s = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign wdata_s     = apb.PWDATA[NUM_CH-1:0];
  assign unused_s    = ^{apb.PADDR[1:0], apb.PWDATA[31:NUM_CH]};

  assign start_req_s = (wr_en_s && addr_word_s == W_CTRL)   ? wdata_s : {NUM_CH{1'b0}};
  assign sts_clr_s   = (wr_en_s && addr_word_s == W_STATUS) ? wdata_s : {NUM_CH{1'b0}};
  assign err_clr_s   = (wr_en_s && addr_word_s == W_ERR)    ? wdata_s : {NUM_CH{1'b0}};
  assign irq_en_wr_s = wr_en_s && (addr_word_s == W_IRQ_EN);

  // Channel state register: one BUSY bit per engine
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      busy_r <= {NUM_CH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Next state: IDLE->BUSY on start request, BUSY->IDLE on acc_done
  always_comb begin
    busy_nxt_s = busy_r;
    for (int c = 0; c < NUM_CH; c++) begin
      case (busy_r[c])
        1'b0:    busy_nxt_s[c] = start_req_s[c];
        1'b1:    busy_nxt_s[c] = ~acc_done[c];
        default: busy_nxt_s[c] = 1'b0;
      endcase
    end
  end

  // FSM outputs: a start while busy is an error, done only counts while busy
  always_comb begin
    start_fire_s = {NUM_CH{1'b0}};
    err_set_s    = {NUM_CH{1'b0}};
    done_set_s   = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      case (busy_r[c])
        1'b0:    start_fire_s[c] = start_req_s[c];
        1'b1: begin
          err_set_s[c]  = start_req_s[c];
          done_set_s[c] = acc_done[c];
        end
        default: start_fire_s[c] = 1'b0;
      endcase
    end
  end

  // Start pulses and flag registers; a hardware set beats a same-edge W1C
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      acc_start_r <= {NUM_CH{1'b0}};
      done_sts_r  <= {NUM_CH{1'b0}};
      err_sts_r   <= {NUM_CH{1'b0}};
      irq_en_r    <= {NUM_CH{1'b0}};
    end else begin
      acc_start_r <= start_fire_s;
      done_sts_r  <= (done_sts_r & ~sts_clr_s) | done_set_s;
      err_sts_r   <= (err_sts_r & ~err_clr_s) | err_set_s;
      if (irq_en_wr_s) begin
        irq_en_r <= wdata_s;
      end else begin
        irq_en_r <= irq_en_r;
      end
    end
  end

  // Latency counters: cleared on start, count every busy edge, saturate
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cycles_r[c] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (start_fire_s[c]) begin
          cycles_r[c] <= {CNT_W{1'b0}};
        end else if (busy_r[c] && (cycles_r[c] != CNT_MAX)) begin
          cycles_r[c] <= cycles_r[c] + CNT_W'(1'b1);
        end else begin
          cycles_r[c] <= cycles_r[c];
        end
      end
    end
  end

  assign cyc_hit_s = (addr_word_s >= W_CYC0) && (addr_word_s < (W_CYC0 + 30'(NUM_CH)));

  // Counter read select
  always_comb begin
    cyc_rd_s = {CNT_W{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      cyc_rd_s = cyc_rd_s | ({CNT_W{addr_word_s == (W_CYC0 + 30'(c))}} & cycles_r[c]);
    end
  end

  // Register read mux
  always_comb begin
    rdata_s = 32'd0;
    case (addr_word_s)
      W_CTRL:   rdata_s[NUM_CH-1:0] = busy_r;
      W_STATUS: rdata_s[NUM_CH-1:0] = done_sts_r;
      W_IRQ_EN: rdata_s[NUM_CH-1:0] = irq_en_r;
      W_ERR:    rdata_s[NUM_CH-1:0] = err_sts_r;
      default: begin
        if (cyc_hit_s) begin
          rdata_s[CNT_W-1:0] = cyc_rd_s;
        end else begin
          rdata_s = 32'd0;
        end
      end
    endcase
  end

  // Read data is captured in the setup phase and otherwise held at zero
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      prdata_r <= 32'd0;
    end else if (rd_setup_s) begin
      prdata_r <= rdata_s;
    end else begin
      prdata_r <= 32'd0;
    end
  end

  assign apb.PRDATA = rd_access_s ? prdata_r : 32'd0;
  assign acc_start  = acc_start_r;
  assign irq        = |(done_sts_r & irq_en_r);
endmodule

// File: tb/tb_apb_accel_ctrl.sv
// Self-checking bench for apb_accel_ctrl: directed scenarios plus randomized
// traffic compared against a timestamp-based behavioural model.
module tb_apb_accel_ctrl;
  logic       PCLK;
  logic       PRESETB;
  logic [3:0] acc_done_a, acc_start_a, acc_done_b, acc_start_b;
  logic       irq_a, irq_b;
  int         n_vec, n_err;

  apb_accel_ctrl_if ia ();
  apb_accel_ctrl_if ib ();

  apb_accel_ctrl #(.NUM_CH(4), .CNT_W(32)) dut_a (
    .PCLK(PCLK), .PRESETB(PRESETB), .apb(ia.slave),
    .acc_done(acc_done_a), .acc_start(acc_start_a), .irq(irq_a)
  );

  apb_accel_ctrl #(.NUM_CH(4), .CNT_W(4)) dut_b (
    .PCLK(PCLK), .PRESETB(PRESETB), .apb(ib.slave),
    .acc_done(acc_done_b), .acc_start(acc_start_b), .irq(irq_b)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Reference model for dut_a: channels remember the edge number they started on
  logic [3:0]  m_busy, m_done, m_err, m_irqen, m_pulse;
  int          m_start [4];
  logic [31:0] m_cyc   [4];
  int          edge_n;
  logic        wr_a;
  logic [31:0] wa_a;

  assign wr_a = ia.PSEL & ia.PENABLE & ia.PWRITE;
  assign wa_a = {ia.PADDR[31:2], 2'b00};

  always @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      m_busy <= 4'd0; m_done <= 4'd0; m_err <= 4'd0; m_irqen <= 4'd0; m_pulse <= 4'd0;
      edge_n <= 0;
      for (int c = 0; c < 4; c++) begin
        m_start[c] <= 0;
        m_cyc[c]   <= 32'd0;
      end
    end else begin
      edge_n <= edge_n + 1;
      if (wr_a && wa_a == 32'h8) m_irqen <= ia.PWDATA[3:0];
      for (int c = 0; c < 4; c++) begin
        m_pulse[c] <= 1'b0;
        if (wr_a && wa_a == 32'h0 && ia.PWDATA[c]) begin
          if (m_busy[c]) begin
            m_err[c] <= 1'b1;
          end else begin
            m_busy[c]  <= 1'b1;
            m_start[c] <= edge_n + 1;
            m_pulse[c] <= 1'b1;
          end
        end
        if (wr_a && wa_a == 32'hC && ia.PWDATA[c]) m_err[c] <= 1'b0;
        if (wr_a && wa_a == 32'h4 && ia.PWDATA[c]) m_done[c] <= 1'b0;
        if (m_busy[c] && acc_done_a[c]) begin
          m_busy[c] <= 1'b0;
          m_done[c] <= 1'b1;
          m_cyc[c]  <= 32'(edge_n + 1 - m_start[c]);
        end
      end
    end
  end

  function automatic logic [31:0] m_reg(input logic [31:0] a);
    logic [31:0] w;
    int          c;
    w = {a[31:2], 2'b00};
    m_reg = 32'd0;
    if (w == 32'h0)      m_reg = {28'd0, m_busy};
    else if (w == 32'h4) m_reg = {28'd0, m_done};
    else if (w == 32'h8) m_reg = {28'd0, m_irqen};
    else if (w == 32'hC) m_reg = {28'd0, m_err};
    else if (w >= 32'h10 && w < 32'h20) begin
      c = int'((w - 32'h10) >> 2);
      m_reg = m_busy[c] ? 32'(edge_n - m_start[c]) : m_cyc[c];
    end
  endfunction

  task automatic bus_set(input bit b, input logic s, input logic e, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (b) begin
      ib.PSEL = s; ib.PENABLE = e; ib.PWRITE = w; ib.PADDR = a; ib.PWDATA = d;
    end else begin
      ia.PSEL = s; ia.PENABLE = e; ia.PWRITE = w; ia.PADDR = a; ia.PWDATA = d;
    end
  endtask

  task automatic apb_write(input bit b, input logic [31:0] a, input logic [31:0] d);
    bus_set(b, 1'b1, 1'b0, 1'b1, a, d);
    @(posedge PCLK); #1;
    bus_set(b, 1'b1, 1'b1, 1'b1, a, d);
    @(posedge PCLK); #1;
    bus_set(b, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic apb_read(input bit b, input logic [31:0] a, output logic [31:0] d);
    bus_set(b, 1'b1, 1'b0, 1'b0, a, 32'd0);
    @(posedge PCLK); #1;
    bus_set(b, 1'b1, 1'b1, 1'b0, a, 32'd0);
    #1;
    d = b ? ib.PRDATA : ia.PRDATA;
    @(posedge PCLK); #1;
    bus_set(b, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    PRESETB = 1'b1;
    #2 PRESETB = 1'b0;
    idle(2);
    n_vec++; if (acc_start_a !== 4'd0 || acc_start_b !== 4'd0) begin n_err++;
      $display("FAIL reset_acc_start: got %h/%h want 0", acc_start_a, acc_start_b); end
    n_vec++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin n_err++;
      $display("FAIL reset_irq: got %b/%b want 0", irq_a, irq_b); end
    PRESETB = 1'b1;
    idle(1);
    n_vec++; if (ia.PRDATA !== 32'd0) begin n_err++;
      $display("FAIL idle_prdata: got %h want 0", ia.PRDATA); end
    for (int i = 0; i < 8; i++) begin
      apb_read(1'b0, 32'(4 * i), got);
      n_vec++; if (got !== 32'd0) begin n_err++;
        $display("FAIL reset_reg_%0h: got %h want 0", 4 * i, got); end
    end
  endtask

  task automatic test_irq_flow();
    logic [31:0] got;
    apb_write(1'b0, 32'h8, 32'h1);
    apb_write(1'b0, 32'h0, 32'h1);
    n_vec++; if (acc_start_a !== 4'b0001) begin n_err++;
      $display("FAIL start_pulse_on: got %b want 0001", acc_start_a); end
    idle(1);
    n_vec++; if (acc_start_a !== 4'b0000) begin n_err++;
      $display("FAIL start_pulse_off: got %b want 0000", acc_start_a); end
    idle(3);
    acc_done_a = 4'b0001;
    idle(1);
    acc_done_a = 4'b0000;
    n_vec++; if (irq_a !== 1'b1) begin n_err++;
      $display("FAIL irq_set: got %b want 1", irq_a); end
    apb_read(1'b0, 32'h10, got);
    n_vec++; if (got !== 32'd5) begin n_err++;
      $display("FAIL cycles0_latency: got %0d want 5", got); end
    apb_read(1'b0, 32'h4, got);
    n_vec++; if (got !== 32'h1) begin n_err++;
      $display("FAIL status_done0: got %h want 1", got); end
    apb_read(1'b0, 32'h0, got);
    n_vec++; if (got !== 32'h0) begin n_err++;
      $display("FAIL busy_cleared: got %h want 0", got); end
    apb_write(1'b0, 32'h4, 32'h1);
    n_vec++; if (irq_a !== 1'b0) begin n_err++;
      $display("FAIL irq_w1c: got %b want 0", irq_a); end
  endtask

  task automatic test_busy_err();
    logic [31:0] got, exp;
    int          e0;
    apb_write(1'b0, 32'h0, 32'h1);
    e0 = edge_n;
    idle(2);
    apb_write(1'b0, 32'h0, 32'h1);
    n_vec++; if (acc_start_a !== 4'b0000) begin n_err++;
      $display("FAIL no_second_pulse: got %b want 0000", acc_start_a); end
    apb_read(1'b0, 32'hC, got);
    n_vec++; if (got !== 32'h1) begin n_err++;
      $display("FAIL err_sticky: got %h want 1", got); end
    exp = 32'(edge_n - e0);
    apb_read(1'b0, 32'h10, got);
    n_vec++; if (got !== exp) begin n_err++;
      $display("FAIL cycles_continue: got %0d want %0d", got, exp); end
    acc_done_a = 4'b0001;
    idle(1);
    acc_done_a = 4'b0000;
    apb_write(1'b0, 32'hC, 32'hF);
    apb_write(1'b0, 32'h4, 32'hF);
    apb_read(1'b0, 32'hC, got);
    n_vec++; if (got !== 32'h0) begin n_err++;
      $display("FAIL err_w1c: got %h want 0", got); end
  endtask

  task automatic test_multi();
    logic [31:0] got;
    apb_write(1'b0, 32'h8, 32'h0);
    apb_write(1'b0, 32'h0, 32'hF);
    n_vec++; if (acc_start_a !== 4'hF) begin n_err++;
      $display("FAIL multi_start: got %b want 1111", acc_start_a); end
    for (int e = 1; e <= 8; e++) begin
      acc_done_a = (e % 2 == 0) ? 4'(1 << (e / 2 - 1)) : 4'd0;
      @(posedge PCLK); #1;
    end
    acc_done_a = 4'd0;
    for (int c = 0; c < 4; c++) begin
      apb_read(1'b0, 32'(16 + 4 * c), got);
      n_vec++; if (got !== 32'(2 * (c + 1))) begin n_err++;
        $display("FAIL multi_cycles%0d: got %0d want %0d", c, got, 2 * (c + 1)); end
    end
    apb_read(1'b0, 32'h4, got);
    n_vec++; if (got !== 32'hF) begin n_err++;
      $display("FAIL multi_status: got %h want f", got); end
    n_vec++; if (irq_a !== 1'b0) begin n_err++;
      $display("FAIL irq_masked: got %b want 0", irq_a); end
    apb_write(1'b0, 32'h8, 32'h4);
    n_vec++; if (irq_a !== 1'b1) begin n_err++;
      $display("FAIL irq_unmask: got %b want 1", irq_a); end
    apb_write(1'b0, 32'h4, 32'hF);
  endtask

  task automatic test_w1c_race();
    logic [31:0] got;
    apb_write(1'b0, 32'h0, 32'h2);
    bus_set(1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h2);
    @(posedge PCLK); #1;
    bus_set(1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h2);
    acc_done_a = 4'b0010;
    @(posedge PCLK); #1;
    bus_set(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    acc_done_a = 4'b0000;
    apb_read(1'b0, 32'h4, got);
    n_vec++; if (got !== 32'h2) begin n_err++;
      $display("FAIL set_beats_w1c: got %h want 2", got); end
    apb_read(1'b0, 32'h14, got);
    n_vec++; if (got !== 32'd2) begin n_err++;
      $display("FAIL race_cycles1: got %0d want 2", got); end
    apb_write(1'b0, 32'h4, 32'h2);
    apb_read(1'b0, 32'h4, got);
    n_vec++; if (got !== 32'h0) begin n_err++;
      $display("FAIL w1c_after_race: got %h want 0", got); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp, a;
    int          op, idx;
    for (int i = 0; i < 300; i++) begin
      n_vec++; if (acc_start_a !== m_pulse) begin n_err++;
        $display("FAIL rnd_acc_start @%0d: got %b want %b", i, acc_start_a, m_pulse); end
      n_vec++; if (irq_a !== (|(m_done & m_irqen))) begin n_err++;
        $display("FAIL rnd_irq @%0d: got %b want %b", i, irq_a, |(m_done & m_irqen)); end
      for (int c = 0; c < 4; c++) acc_done_a[c] = ($urandom_range(0, 3) == 0);
      op = $urandom_range(0, 5);
      case (op)
        0: apb_write(1'b0, 32'h0, $urandom);
        1: apb_write(1'b0, 32'h4, $urandom);
        2: apb_write(1'b0, 32'hC, $urandom);
        3: apb_write(1'b0, 32'h8, $urandom);
        4: begin
          idx = $urandom_range(0, 9);
          a = (idx < 8) ? 32'(4 * idx) : ((idx == 8) ? 32'h20 : 32'h1000);
          a = a | 32'($urandom_range(0, 3));
          exp = m_reg(a);
          apb_read(1'b0, a, got);
          n_vec++; if (got !== exp) begin n_err++;
            $display("FAIL rnd_read %h @%0d: got %h want %h", a, i, got, exp); end
        end
        default: idle($urandom_range(1, 3));
      endcase
    end
    acc_done_a = 4'd0;
  endtask

  task automatic test_saturate_reset();
    logic [31:0] got;
    apb_write(1'b0, 32'h0, 32'h4);
    apb_write(1'b1, 32'h0, 32'h1);
    n_vec++; if (acc_start_b !== 4'b0001) begin n_err++;
      $display("FAIL b_start: got %b want 0001", acc_start_b); end
    idle(20);
    apb_read(1'b1, 32'h10, got);
    n_vec++; if (got !== 32'd15) begin n_err++;
      $display("FAIL b_saturate: got %0d want 15", got); end
    apb_read(1'b1, 32'h0, got);
    n_vec++; if (got !== 32'h1) begin n_err++;
      $display("FAIL b_busy: got %h want 1", got); end
    PRESETB = 1'b0;
    idle(2);
    PRESETB = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      n_vec++; if (acc_start_a !== 4'd0 || acc_start_b !== 4'd0) begin n_err++;
        $display("FAIL post_reset_pulse: got %b/%b want 0", acc_start_a, acc_start_b); end
    end
    apb_read(1'b1, 32'h0, got);
    n_vec++; if (got !== 32'h0) begin n_err++;
      $display("FAIL b_reset_busy: got %h want 0", got); end
    apb_read(1'b1, 32'h10, got);
    n_vec++; if (got !== 32'h0) begin n_err++;
      $display("FAIL b_reset_cycles: got %h want 0", got); end
    apb_read(1'b1, 32'h4, got);
    n_vec++; if (got !== 32'h0) begin n_err++;
      $display("FAIL b_reset_status: got %h want 0", got); end
    apb_read(1'b0, 32'h0, got);
    n_vec++; if (got !== 32'h0) begin n_err++;
      $display("FAIL a_reset_busy: got %h want 0", got); end
    apb_read(1'b0, 32'h18, got);
    n_vec++; if (got !== 32'h0) begin n_err++;
      $display("FAIL a_reset_cycles2: got %h want 0", got); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    acc_done_a = 4'd0;
    acc_done_b = 4'd0;
    bus_set(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus_set(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_irq_flow();
    test_busy_err();
    test_multi();
    test_w1c_race();
    test_random();
    test_saturate_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
